vga_frame_writer: RTL and testbench
===================================

# vga_frame_writer

Write-side engine for the two VGA character/pixel memories. It accepts burst commands from the Nios bus glue and drives the `data` / `wraddress` / `wren` / `memorySel` inputs of `vgaController`. Each burst is either a constant fill or a streamed word sequence. A burst can optionally be held until the start of vertical blanking to avoid tearing. The block sits between the processor interface and `vgaController` and is the only writer of both memories.

## Interface
- `DATA_W`, 32, memory word width
- `ADDR_W`, 6, memory address width; depth = 2**ADDR_W = 64 words

- `clk`  in  1  system clock, the same clock that feeds `vgaController.clk`
- `rst`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_start`  in  ADDR_W  first write address
- `cmd_len`  in  ADDR_W+1  word count, 0..64
- `cmd_fill`  in  1  1 = write `cmd_data` `cmd_len` times; 0 = take words from the stream port
- `cmd_data`  in  DATA_W  fill pattern
- `cmd_sel`  in  1  target memory: 0 = memory32, 1 = memory64
- `cmd_vsync`  in  1  1 = delay the burst until the next vsync falling edge
- `in_valid`  in  1  stream word offered
- `in_ready`  out  1  stream word accepted when `in_valid && in_ready`
- `in_data`  in  DATA_W  stream word
- `vsync`  in  1  from `vgaController`, active-low pulse
- `data`  out  DATA_W  to memory write data
- `wraddress`  out  ADDR_W  to memory write address
- `wren`  out  1  to memory write enable
- `memorySel`  out  1  to the memory mux
- `busy`  out  1  high when not in IDLE
- `done`  out  1  one-cycle pulse when a burst completes

## Operation
- States and transitions:
  - IDLE goes to WAIT_VS on accept with `cmd_vsync`=1.
  - IDLE goes to WRITE on accept with `cmd_vsync`=0 and `cmd_len`≠0.
  - IDLE goes to IDLE, with a `done` pulse, on accept with `cmd_len`=0.
  - WAIT_VS goes to WRITE on a detected vsync falling edge. If `cmd_len`=0, it goes to IDLE with a `done` pulse instead.
  - WRITE goes to IDLE when the remaining count reaches 0.
- Accept happens on `cmd_valid && cmd_ready`. All command fields are latched at accept. Fields are ignored while `busy`=1.
- `memorySel` loads `cmd_sel` at accept and holds until the next accept. Because of this, the select is stable for the whole burst.
- Address counter:
  - Loads `cmd_start` at burst start and increments after each write.
  - Wraps modulo 2**ADDR_W (63 goes to 0).
  - No error on wrap.
- Remaining counter:
  - ADDR_W+1 bits, loaded with `cmd_len`.
  - Decrements once per write.
  - Never underflows.
- Fill mode: one write per cycle, with `data` = latched `cmd_data`.
- Stream mode:
  - `in_ready` = (state==WRITE) && remaining≠0 && !`cmd_fill`.
  - An accepted word is written the next cycle.
  - Gaps in `in_valid` produce `wren`=0 cycles. Address and count do not advance during gaps.
- `vsync` passes through a 2-flop synchronizer plus a falling-edge detector. A falling edge that occurs before WAIT_VS is entered is not counted.
- Registered outputs after reset deasserts:
  - `data`=0, `wraddress`=0, `wren`=0, `memorySel`=0.
  - `busy`=0, `done`=0, `in_ready`=0.
  - `cmd_ready`=1.
- Reset mid-burst:
  - `wren` drops immediately (asynchronous reset).
  - The burst is discarded and the state returns to IDLE.
  - No `done` is issued.

## Timing
- Fill without vsync wait, accepted in cycle T:
  - `wren`=1 during cycles T+1..T+len, with consecutive addresses.
  - `done`=1 in T+len+1. `busy` falls in T+len+1.
  - `cmd_ready`=1 in T+len+1, so back-to-back bursts lose one cycle.
- Stream mode:
  - `in_ready` rises in T+1.
  - A word accepted in cycle S gives `wren` in S+1.
  - `done` comes one cycle after the last `wren`.
- vsync wait:
  - An edge-detect pulse in cycle E acts as an accept in cycle E.
  - Raw vsync fall to pulse is 2–3 clk cycles.
- `cmd_len`=0 accepted in T: `done` in T+1, no `wren`, `cmd_ready` stays 1.
- `wren` is never high outside WRITE+1. No write is ever issued to an address twice within a burst of 64 or fewer words.

## Structure
- Package `vga_writer_pkg`:
  - State enum: IDLE, WAIT_VS, WRITE.
  - Default `DATA_W`/`ADDR_W` constants.
  - Command struct: start, len, fill, data, sel, vsync.
- Sub-module `vsync_edge_det`: 2-flop synchronizer plus falling-edge pulse, with active-low async reset.
- Everything else stays in the top module: FSM, counters, output registers.

## Test plan
- Fill, start=62, len=4, data=0xA5A5A5A5, sel=1 -> `wren` in T+1..T+4 at addresses 62, 63, 0, 1; `memorySel`=1 throughout; `done` in T+5.
- Stream, start=10, len=3, words 0x1, 0x2, 0x3, with a 2-cycle `in_valid` gap after the first word -> writes 0x1@10, 0x2@11, 0x3@12; `wren` low during the gap; `done` the cycle after 0x3 is written.
- Fill with vsync wait, len=2 -> no `wren` until the edge pulse; then writes in E+1 and E+2; `busy` high from T+1 to E+2.
- len=0 -> `done` in T+1, zero writes; a second `cmd_valid` held during `busy` of another burst is not accepted until `cmd_ready` returns.
- Reset asserted during the 3rd write of a len=8 fill -> `wren`=0 immediately, all outputs at reset values, `cmd_ready`=1 after release, no `done`.
- len=64 full-memory stream from start=5 -> 64 writes covering every address exactly once, ending at address 4.

Source files
------------

// File: rtl/vga_writer_pkg.sv
// Shared types and default widths for the VGA memory write engine.
package vga_writer_pkg;

  localparam int VGA_DATA_W = 32;
  localparam int VGA_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    WRITE   = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [VGA_ADDR_W-1:0] start;
    logic [VGA_ADDR_W:0]   len;
    logic                  fill;
    logic [VGA_DATA_W-1:0] data;
    logic                  sel;
    logic                  vsync;
  } wr_cmd_t;

endpackage

// File: rtl/vsync_edge_det.sv
// Two-flop synchronizer on the raw vsync plus a one-cycle falling-edge pulse.
module vsync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic fall
);

  logic [2:0] sync;

  // Reset to the inactive (high) level so release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[1:0], vsync};
  end

  assign fall = sync[2] & ~sync[1];

endmodule

// File: rtl/vga_frame_writer.sv
// Burst write engine for the two vgaController memories: constant fill or
// streamed words, optionally deferred to the next vertical blanking edge.
module vga_frame_writer
  import vga_writer_pkg::*;
#(
  parameter int DATA_W = VGA_DATA_W,
  parameter int ADDR_W = VGA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_start,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              cmd_fill,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_sel,
  input  logic              cmd_vsync,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              vsync,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] wraddress,
  output logic              wren,
  output logic              memorySel,
  output logic              busy,
  output logic              done
);

  wr_state_e         state, state_nxt;
  wr_cmd_t           cmd_in, cmd_q, cmd_cur;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem;
  logic              vs_fall, accept, launch, launch_wr, step_wr, finish;

  vsync_edge_det u_vs_det (
    .clk   (clk),
    .rst_n (rst),
    .vsync (vsync),
    .fall  (vs_fall)
  );

  assign cmd_in = '{start: cmd_start, len: cmd_len, fill: cmd_fill,
                    data: cmd_data, sel: cmd_sel, vsync: cmd_vsync};
  assign accept = cmd_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = cmd_vsync ? WAIT_VS
                                     : ((cmd_len == '0) ? IDLE : WRITE);
      WAIT_VS: if (vs_fall) state_nxt = (cmd_q.len == '0) ? IDLE : WRITE;
      WRITE:   if (rem == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A burst "launches" either at a plain accept or at the vsync edge; the
  // edge reuses the latched command exactly as if it had just been accepted.
  always_comb begin
    cmd_cur   = (state == IDLE) ? cmd_in : cmd_q;
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    in_ready  = (state == WRITE) && (rem != '0) && !cmd_q.fill;
    launch    = (accept && !cmd_cur.vsync) || ((state == WAIT_VS) && vs_fall);
    launch_wr = launch && cmd_cur.fill && (cmd_cur.len != '0);
    step_wr   = (state == WRITE) && (rem != '0) && (cmd_q.fill || in_valid);
    finish    = ((state == WRITE) && (rem == '0)) || (launch && (cmd_cur.len == '0));
  end

  // rem counts writes not yet issued; a fill issues its first write at launch
  // so wren lines up with the first WRITE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q     <= '0;
      memorySel <= 1'b0;
      addr      <= '0;
      rem       <= '0;
      data      <= '0;
      wraddress <= '0;
      wren      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wren <= 1'b0;
      done <= finish;
      if (accept) begin
        cmd_q     <= cmd_in;
        memorySel <= cmd_cur.sel;
      end
      if (launch_wr) begin
        wren      <= 1'b1;
        wraddress <= cmd_cur.start;
        data      <= cmd_cur.data;
        addr      <= cmd_cur.start + 1'b1;
        rem       <= cmd_cur.len - 1'b1;
      end else if (launch) begin
        addr <= cmd_cur.start;
        rem  <= cmd_cur.len;
      end else if (step_wr) begin
        wren      <= 1'b1;
        wraddress <= addr;
        data      <= cmd_q.fill ? cmd_q.data : in_data;
        addr      <= addr + 1'b1;
        rem       <= rem - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_writer.sv
// Randomized and directed bursts checked against a write-list/timing model.
module tb_vga_frame_writer;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0, rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_fill = 1'b0, cmd_sel = 1'b0, cmd_vsync = 1'b0;
  logic [AW-1:0] cmd_start = '0;
  logic [AW:0]   cmd_len = '0;
  logic [DW-1:0] cmd_data = '0, in_data = '0;
  logic          in_valid = 1'b0, vsync = 1'b1;
  logic          cmd_ready, in_ready, wren, memorySel, busy, done;
  logic [DW-1:0] data;
  logic [AW-1:0] wraddress;

  vga_frame_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .cmd_data(cmd_data), .cmd_sel(cmd_sel), .cmd_vsync(cmd_vsync),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .vsync(vsync), .data(data), .wraddress(wraddress), .wren(wren),
    .memorySel(memorySel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Observed writes and done pulses, sampled mid-cycle.
  int          wr_cyc[$], wr_addr[$], done_cyc[$];
  logic [DW-1:0] wr_data[$];
  logic        wr_sel[$];
  int          ex_cyc[$], ex_addr[$];
  logic [DW-1:0] ex_data[$];
  logic        ex_sel[$];

  always @(negedge clk) begin
    if (wren) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(wraddress));
      wr_data.push_back(data);
      wr_sel.push_back(memorySel);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic clear_obs();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_sel.delete();
    ex_cyc.delete(); ex_addr.delete(); ex_data.delete(); ex_sel.delete();
    done_cyc.delete();
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, "_nwr"}, wr_cyc.size(), ex_cyc.size());
    n = (wr_cyc.size() < ex_cyc.size()) ? wr_cyc.size() : ex_cyc.size();
    for (int k = 0; k < n; k++) begin
      chk({tag, "_addr"}, wr_addr[k], ex_addr[k]);
      chk({tag, "_data"}, wr_data[k], ex_data[k]);
      chk({tag, "_cyc"},  wr_cyc[k],  ex_cyc[k]);
      chk({tag, "_sel"},  wr_sel[k],  ex_sel[k]);
    end
  endtask

  task automatic wait_done(input string tag, output int dc);
    int n;
    n  = 0;
    dc = -1;
    while (dc < 0 && n < 400) begin
      @(negedge clk); #1;
      if (done_cyc.size() > 0) begin
        dc = done_cyc.pop_front();
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_ready_at_done"}, cmd_ready, 1);
      end
      n++;
    end
    if (dc < 0) chk({tag, "_done_timeout"}, 0, 1);
    else begin
      @(negedge clk); #1;
      chk({tag, "_done_1cyc"}, done, 0);
    end
  endtask

  task automatic run_burst(input string tag, input int start, input int len, input bit fill,
                           input logic [DW-1:0] dat, input bit sel, input bit vs,
                           input int gap_pct, input int gap1, input int vs_delay,
                           input bit cnt_words);
    logic [DW-1:0] words[$];
    int acc[$];
    int t, f, e, dc, idx, guard, skip, base, exp_done;
    bit took;
    for (int k = 0; k < len; k++) words.push_back(cnt_words ? DW'(k + 1) : DW'($urandom));
    @(posedge clk); #1;
    guard = 0;
    while (!cmd_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    clear_obs();
    cmd_valid = 1'b1; cmd_start = start[AW-1:0]; cmd_len = len[AW:0];
    cmd_fill = fill; cmd_data = dat; cmd_sel = sel; cmd_vsync = vs;
    t = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (vs || len > 0) chk({tag, "_busy"}, busy, 1);
    f = -100;
    if (vs) begin
      repeat (vs_delay) begin @(posedge clk); #1; end
      chk({tag, "_vs_hold"}, wr_cyc.size() + done_cyc.size(), 0);
      vsync = 1'b0;
      f = cyc;
      fork begin repeat (5) @(posedge clk); #1 vsync = 1'b1; end join_none
    end
    if (!fill && len > 0) begin
      idx = 0; guard = 0; skip = 0;
      while (idx < len && guard < 1000) begin
        if (skip > 0) begin in_valid = 1'b0; skip--; end
        else if (int'($urandom_range(99)) < gap_pct) in_valid = 1'b0;
        else begin in_valid = 1'b1; in_data = words[idx]; end
        @(negedge clk);
        if (!vs && guard == 0) chk({tag, "_in_ready_rise"}, in_ready, 1);
        took = in_valid && in_ready;
        if (took) acc.push_back(cyc);
        @(posedge clk); #1;
        if (took) begin idx++; if (idx == 1) skip = gap1; end
        guard++;
      end
      in_valid = 1'b0;
      chk({tag, "_stream_accepts"}, idx, len);
    end
    wait_done(tag, dc);
    // The edge pulse cycle is only bounded (2-3 cycles after the raw fall).
    e = 0;
    if (vs) begin
      if (len == 0)          e = dc - 1;
      else if (fill)         e = (wr_cyc.size() > 0) ? wr_cyc[0] - 1 : 0;
      if (fill || len == 0)  chk({tag, "_vs_lat"}, (e - f >= 2) && (e - f <= 3), 1);
      else                   chk({tag, "_vs_stream_lat"}, (acc.size() > 0) && (acc[0] >= f + 3), 1);
    end
    base = vs ? e : t;
    for (int k = 0; k < len; k++) begin
      ex_addr.push_back((start + k) % DEPTH);
      ex_data.push_back(fill ? dat : words[k]);
      ex_sel.push_back(sel);
      if (fill)                ex_cyc.push_back(base + 1 + k);
      else if (k < acc.size()) ex_cyc.push_back(acc[k] + 1);
      else                     ex_cyc.push_back(-1);
    end
    exp_done = (len == 0) ? base + 1 : ex_cyc[len-1] + 1;
    chk({tag, "_done_cyc"}, dc, exp_done);
    compare_writes(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, t2, n, dc;
    bit seen[DEPTH];
    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_data", data, 0);       chk("rst_wraddress", wraddress, 0);
    chk("rst_wren", wren, 0);       chk("rst_memsel", memorySel, 0);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0); chk("rst_cmd_ready", cmd_ready, 1);

    // Directed scenarios
    run_burst("fill_wrap", 62, 4, 1, 32'hA5A5_A5A5, 1, 0, 0, 0, 0, 0);
    run_burst("stream_gap", 10, 3, 0, 0, 0, 0, 0, 2, 0, 1);
    vsync = 1'b0;                     // edge before WAIT_VS must be ignored
    repeat (3) @(posedge clk);
    #1 vsync = 1'b1;
    run_burst("fill_vs", 20, 2, 1, 32'h1234_5678, 0, 1, 0, 0, 6, 0);
    run_burst("len0", 7, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0);
    run_burst("len0_vs", 7, 0, 0, 0, 0, 1, 0, 0, 3, 0);
    run_burst("stream_full", 5, 64, 0, 0, 1, 0, 20, 0, 0, 0);
    for (int a = 0; a < DEPTH; a++) seen[a] = 1'b0;
    for (int k = 0; k < wr_addr.size(); k++) seen[wr_addr[k]] = 1'b1;
    n = 0;
    for (int a = 0; a < DEPTH; a++) n += seen[a];
    chk("full_cover", n, DEPTH);
    chk("full_last_addr", (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : -1, 4);

    // Command held during another burst waits for cmd_ready
    @(posedge clk); #1;
    clear_obs();
    cmd_valid = 1; cmd_start = 30; cmd_len = 6; cmd_fill = 1; cmd_data = 32'h1111_1111;
    cmd_sel = 0; cmd_vsync = 0;
    t = cyc;
    @(posedge clk); #1;
    cmd_start = 40; cmd_len = 2; cmd_data = 32'h2222_2222; cmd_sel = 1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    t2 = cyc;
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("hold_accept_cyc", t2, t + 7);
    for (int k = 0; k < 6; k++) begin
      ex_addr.push_back(30 + k); ex_data.push_back(32'h1111_1111);
      ex_sel.push_back(1'b0);    ex_cyc.push_back(t + 1 + k);
    end
    for (int k = 0; k < 2; k++) begin
      ex_addr.push_back(40 + k); ex_data.push_back(32'h2222_2222);
      ex_sel.push_back(1'b1);    ex_cyc.push_back(t2 + 1 + k);
    end
    repeat (5) @(posedge clk); #1;
    compare_writes("hold");
    chk("hold_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      chk("hold_done0", done_cyc[0], t + 7);
      chk("hold_done1", done_cyc[1], t2 + 3);
    end

    // Reset during the 3rd write of a len=8 fill
    @(posedge clk); #1;
    clear_obs();
    cmd_valid = 1; cmd_start = 50; cmd_len = 8; cmd_fill = 1; cmd_data = 32'hCAFE_F00D;
    cmd_sel = 1; cmd_vsync = 0;
    @(posedge clk); #1 cmd_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_rst_pre_wren", wren, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_wren", wren, 0);         chk("mid_rst_data", data, 0);
    chk("mid_rst_wraddress", wraddress, 0); chk("mid_rst_memsel", memorySel, 0);
    chk("mid_rst_busy", busy, 0);         chk("mid_rst_done", done, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    done_cyc.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cyc.size(), 0);
    chk("mid_rst_ready", cmd_ready, 1);

    // Randomized bursts
    for (int i = 0; i < 25; i++) begin
      int len;
      len = ($urandom_range(3) == 0) ? int'($urandom_range(64)) : int'($urandom_range(12));
      run_burst("rand", int'($urandom_range(DEPTH - 1)), len, 1'($urandom_range(1)),
                $urandom, 1'($urandom_range(1)), ($urandom_range(3) == 0),
                int'($urandom_range(50)), int'($urandom_range(2)),
                int'($urandom_range(1, 8)), 1'b0);
    end
    dc = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + dc);
    $finish;
  end

endmodule
